// File: rtl/rf_sched_pkg.sv
// rtl/rf_sched_pkg.sv - shared widths and write-port source encoding for the RF write scheduler
package rf_sched_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_HOLD,
    SRC_LLU
  } wr_src_t;
endpackage

// File: rtl/rf_write_scheduler_if.sv
// rtl/rf_write_scheduler_if.sv - issue, writeback, LLU and regfile-port bundle for the scheduler
interface rf_write_scheduler_if;
  import rf_sched_pkg::*;

  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs1;
  logic [REG_AW-1:0] issue_rs2;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_use_rs1;
  logic              issue_use_rs2;
  logic              issue_wr_rd;
  logic              issue_long;
  logic              issue_stall;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              llu_valid;
  logic [REG_AW-1:0] llu_rd;
  logic [XLEN-1:0]   llu_data;
  logic              llu_ready;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_din;

  logic [REG_AW:0]   busy_count;

  // Pipeline side: decode, writeback and the LLU drive requests.
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output issue_use_rs1, issue_use_rs2, issue_wr_rd, issue_long,
    input  issue_stall,
    output wb_valid, wb_rd, wb_data,
    output llu_valid, llu_rd, llu_data,
    input  llu_ready,
    input  rf_we, rf_rd, rf_din,
    input  busy_count
  );

  // Scheduler side.
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  issue_use_rs1, issue_use_rs2, issue_wr_rd, issue_long,
    output issue_stall,
    input  wb_valid, wb_rd, wb_data,
    input  llu_valid, llu_rd, llu_data,
    output llu_ready,
    output rf_we, rf_rd, rf_din,
    output busy_count
  );
endinterface

// File: rtl/rf_hold_buffer.sv
// rtl/rf_hold_buffer.sv - one-entry holding register for an LLU result that lost the write port
module rf_hold_buffer
  import rf_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [REG_AW-1:0] load_rd,
  input  logic [XLEN-1:0]   load_data,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   data
);

  // Load only happens while empty and drain only while full, so the two never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= load_rd;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - regfile write-port arbiter and LLU scoreboard with hazard stall
module rf_write_scheduler
  import rf_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rf_write_scheduler_if.slave  bus
);

  // x0 never carries a pending write.
  localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_eff;
  logic [NUM_REGS-1:0] clr_eff;
  logic [REG_AW:0]     count;

  logic                hold_valid;
  logic [REG_AW-1:0]   hold_rd;
  logic [XLEN-1:0]     hold_data;
  logic                hold_load;
  logic                hold_drain;

  wr_src_t             src;
  logic [REG_AW-1:0]   sel_rd;
  logic [XLEN-1:0]     sel_din;
  logic                issue_fire;

  // Hazard check: any used source or the destination still waiting on an LLU write.
  always_comb begin
    bus.issue_stall = reset ||
                      (bus.issue_valid &&
                       ((bus.issue_use_rs1 && busy[bus.issue_rs1]) ||
                        (bus.issue_use_rs2 && busy[bus.issue_rs2]) ||
                        (bus.issue_wr_rd   && busy[bus.issue_rd])));
  end

  assign issue_fire    = bus.issue_valid && !bus.issue_stall;
  assign bus.llu_ready = !hold_valid && !reset;

  // Fixed priority: writeback, then the held LLU result, then a fresh LLU result.
  always_comb begin
    src = SRC_NONE;
    if (reset)               src = SRC_NONE;
    else if (bus.wb_valid)   src = SRC_WB;
    else if (hold_valid)     src = SRC_HOLD;
    else if (bus.llu_valid)  src = SRC_LLU;
  end

  // Port mux; x0 writes are suppressed at the enable only.
  always_comb begin
    sel_rd  = '0;
    sel_din = '0;
    unique case (src)
      SRC_WB:   begin sel_rd = bus.wb_rd;  sel_din = bus.wb_data;  end
      SRC_HOLD: begin sel_rd = hold_rd;    sel_din = hold_data;    end
      SRC_LLU:  begin sel_rd = bus.llu_rd; sel_din = bus.llu_data; end
      default:  begin sel_rd = '0;         sel_din = '0;           end
    endcase
    bus.rf_we  = (src != SRC_NONE) && (sel_rd != '0);
    bus.rf_rd  = sel_rd;
    bus.rf_din = sel_din;
  end

  // An LLU result accepted while writeback owns the port is parked in the hold buffer.
  assign hold_load  = bus.llu_valid && bus.llu_ready && bus.wb_valid;
  assign hold_drain = (src == SRC_HOLD);

  rf_hold_buffer u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .drain     (hold_drain),
    .load_rd   (bus.llu_rd),
    .load_data (bus.llu_data),
    .valid     (hold_valid),
    .rd        (hold_rd),
    .data      (hold_data)
  );

  // Scoreboard updates: long issue sets, LLU-sourced port writes clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_fire && bus.issue_long && bus.issue_wr_rd && (bus.issue_rd != '0))
      set_vec[bus.issue_rd] = 1'b1;
    if (src == SRC_HOLD)
      clr_vec[hold_rd] = 1'b1;
    else if (src == SRC_LLU)
      clr_vec[bus.llu_rd] = 1'b1;
    // Only transitions that actually change a bit move the counter; set beats clear.
    set_eff = set_vec & ~busy;
    clr_eff = clr_vec & busy & ~set_vec;
  end

  // Busy bits and their running population count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy <= ((busy & ~clr_vec) | set_vec) & X0_MASK;
      unique case ({|set_eff, |clr_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.busy_count = count;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - self-checking bench for rf_write_scheduler with a reference model
module tb_rf_write_scheduler;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  rf_write_scheduler_if bus();

  rf_write_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: which registers await an LLU write, and the parked result.
  bit          m_busy [32];
  bit          m_hold_valid;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_data;

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit exp_stall();
    if (reset) return 1'b1;
    if (!bus.issue_valid) return 1'b0;
    return (bus.issue_use_rs1 && m_busy[bus.issue_rs1]) ||
           (bus.issue_use_rs2 && m_busy[bus.issue_rs2]) ||
           (bus.issue_wr_rd   && m_busy[bus.issue_rd]);
  endfunction

  function automatic bit exp_ready();
    return !reset && !m_hold_valid;
  endfunction

  // 0 idle, 1 writeback, 2 held result, 3 direct LLU result
  function automatic int exp_src();
    if (reset) return 0;
    if (bus.wb_valid) return 1;
    if (m_hold_valid) return 2;
    if (bus.llu_valid) return 3;
    return 0;
  endfunction

  function automatic logic [4:0] exp_rd();
    case (exp_src())
      1: return bus.wb_rd;
      2: return m_hold_rd;
      3: return bus.llu_rd;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_din();
    case (exp_src())
      1: return bus.wb_data;
      2: return m_hold_data;
      3: return bus.llu_data;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit exp_we();
    return (exp_src() != 0) && (exp_rd() != 5'd0);
  endfunction

  task automatic model_tick();
    int s;
    bit fire, accept;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_hold_valid = 1'b0;
      return;
    end
    s      = exp_src();
    fire   = bus.issue_valid && !exp_stall();
    accept = bus.llu_valid && exp_ready();
    if (s == 2) begin
      m_busy[m_hold_rd] = 1'b0;
      m_hold_valid = 1'b0;
    end else if (s == 3) begin
      m_busy[bus.llu_rd] = 1'b0;
    end
    if (accept && bus.wb_valid) begin
      m_hold_valid = 1'b1;
      m_hold_rd    = bus.llu_rd;
      m_hold_data  = bus.llu_data;
    end
    if (fire && bus.issue_long && bus.issue_wr_rd && bus.issue_rd != 5'd0)
      m_busy[bus.issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 0;
    bus.issue_use_rs1 = 0; bus.issue_use_rs2 = 0; bus.issue_wr_rd = 0; bus.issue_long = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.llu_valid = 0; bus.llu_rd = 0; bus.llu_data = 0;
  endtask

  task automatic issue_long_rd(input logic [4:0] rd);
    idle();
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_wr_rd = 1; bus.issue_rd = rd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    bus.llu_valid = 1; bus.llu_rd = 5'd4; bus.llu_data = 32'h1234;
    tick();
    #2;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.rf_we); end
    checks++; if (bus.llu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.llu_ready); end
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", bus.issue_stall); end
    tick();
    reset = 0;
    idle();
    bus.issue_valid = 1; bus.issue_use_rs1 = 1; bus.issue_rs1 = 5'd4;
    #2;
    checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.busy_count); end
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b want 0", bus.issue_stall); end
    checks++; if (bus.llu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.llu_ready); end
    idle();
    tick();
  endtask

  task automatic test_raw();
    idle();
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_wr_rd = 1; bus.issue_rd = 5'd5;
    #2;
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall: got %b want 0", bus.issue_stall); end
    tick();
    idle();
    #2;
    checks++; if (bus.busy_count !== 6'd1) begin errors++; $display("FAIL raw_count_set: got %0d want 1", bus.busy_count); end
    bus.issue_valid = 1; bus.issue_use_rs1 = 1; bus.issue_rs1 = 5'd5;
    bus.llu_valid = 1; bus.llu_rd = 5'd5; bus.llu_data = 32'hDEAD_BEEF;
    #2;
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", bus.issue_stall); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5) begin errors++; $display("FAIL raw_llu_write: got we=%b rd=%0d want we=1 rd=5", bus.rf_we, bus.rf_rd); end
    checks++; if (bus.rf_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_llu_din: got %h want deadbeef", bus.rf_din); end
    tick();
    bus.llu_valid = 0;
    #2;
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_drop: got %b want 0", bus.issue_stall); end
    checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL raw_count_clear: got %0d want 0", bus.busy_count); end
    idle();
    tick();
  endtask

  task automatic test_collision();
    issue_long_rd(5'd7);
    bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h11;
    bus.llu_valid = 1; bus.llu_rd = 5'd7; bus.llu_data = 32'h22;
    #2;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_din !== 32'h11) begin errors++; $display("FAIL coll_wb: got we=%b rd=%0d din=%h want 1/3/11", bus.rf_we, bus.rf_rd, bus.rf_din); end
    checks++; if (bus.llu_ready !== 1'b1) begin errors++; $display("FAIL coll_ready0: got %b want 1", bus.llu_ready); end
    tick();
    idle();
    #2;
    checks++; if (bus.llu_ready !== 1'b0) begin errors++; $display("FAIL coll_ready1: got %b want 0", bus.llu_ready); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_din !== 32'h22) begin errors++; $display("FAIL coll_hold: got we=%b rd=%0d din=%h want 1/7/22", bus.rf_we, bus.rf_rd, bus.rf_din); end
    tick();
    #2;
    checks++; if (bus.llu_ready !== 1'b1) begin errors++; $display("FAIL coll_ready2: got %b want 1", bus.llu_ready); end
    checks++; if (bus.rf_we !== 1'b0 || bus.busy_count !== 6'd0) begin errors++; $display("FAIL coll_done: got we=%b count=%0d want 0/0", bus.rf_we, bus.busy_count); end
    tick();
  endtask

  task automatic test_sustained();
    issue_long_rd(5'd10);
    bus.wb_valid = 1; bus.wb_rd = 5'd1; bus.wb_data = 32'h100;
    bus.llu_valid = 1; bus.llu_rd = 5'd10; bus.llu_data = 32'hABCD;
    tick();
    bus.llu_valid = 0; bus.llu_rd = 5'd0; bus.llu_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      bus.wb_rd = 5'(i + 2); bus.wb_data = 32'(i + 'h200);
      #2;
      checks++; if (bus.llu_ready !== 1'b0) begin errors++; $display("FAIL sust_ready[%0d]: got %b want 0", i, bus.llu_ready); end
      checks++; if (bus.rf_rd !== 5'(i + 2) || bus.busy_count !== 6'd1) begin errors++; $display("FAIL sust_wb[%0d]: got rd=%0d count=%0d want rd=%0d count=1", i, bus.rf_rd, bus.busy_count, i + 2); end
      tick();
    end
    bus.wb_valid = 0;
    #2;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd10 || bus.rf_din !== 32'hABCD) begin errors++; $display("FAIL sust_drain: got we=%b rd=%0d din=%h want 1/10/abcd", bus.rf_we, bus.rf_rd, bus.rf_din); end
    tick();
    #2;
    checks++; if (bus.busy_count !== 6'd0 || bus.llu_ready !== 1'b1) begin errors++; $display("FAIL sust_after: got count=%0d ready=%b want 0/1", bus.busy_count, bus.llu_ready); end
    idle();
  endtask

  task automatic test_x0();
    idle();
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_wr_rd = 1; bus.issue_rd = 5'd0;
    #2;
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL x0_issue_stall: got %b want 0", bus.issue_stall); end
    tick();
    idle();
    #2;
    checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL x0_count: got %0d want 0", bus.busy_count); end
    bus.llu_valid = 1; bus.llu_rd = 5'd0; bus.llu_data = 32'h5;
    #2;
    checks++; if (bus.rf_we !== 1'b0 || bus.llu_ready !== 1'b1) begin errors++; $display("FAIL x0_llu: got we=%b ready=%b want 0/1", bus.rf_we, bus.llu_ready); end
    tick();
    issue_long_rd(5'd6);
    bus.issue_valid = 1; bus.issue_use_rs1 = 1; bus.issue_rs1 = 5'd0;
    bus.issue_use_rs2 = 1; bus.issue_rs2 = 5'd0; bus.issue_wr_rd = 1; bus.issue_rd = 5'd0;
    #2;
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL x0_src_stall: got %b want 0", bus.issue_stall); end
    idle();
    bus.llu_valid = 1; bus.llu_rd = 5'd6;
    tick();
    idle();
  endtask

  task automatic test_waw();
    issue_long_rd(5'd9);
    issue_long_rd(5'd12);
    #2;
    checks++; if (bus.busy_count !== 6'd2) begin errors++; $display("FAIL waw_count2: got %0d want 2", bus.busy_count); end
    bus.issue_valid = 1; bus.issue_wr_rd = 1; bus.issue_rd = 5'd9;
    #2;
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", bus.issue_stall); end
    idle();
    bus.llu_valid = 1; bus.llu_rd = 5'd9;
    tick();
    bus.llu_rd = 5'd12;
    #2;
    checks++; if (bus.busy_count !== 6'd1) begin errors++; $display("FAIL waw_count1: got %0d want 1", bus.busy_count); end
    tick();
    idle();
    #2;
    checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL waw_count0: got %0d want 0", bus.busy_count); end
  endtask

  task automatic test_reset_mid();
    issue_long_rd(5'd1);
    issue_long_rd(5'd2);
    issue_long_rd(5'd3);
    bus.wb_valid = 1; bus.wb_rd = 5'd20; bus.wb_data = 32'h1;
    bus.llu_valid = 1; bus.llu_rd = 5'd1; bus.llu_data = 32'h55;
    tick();
    idle();
    #2;
    checks++; if (bus.busy_count !== 6'd3 || bus.llu_ready !== 1'b0) begin errors++; $display("FAIL rmid_pre: got count=%0d ready=%b want 3/0", bus.busy_count, bus.llu_ready); end
    reset = 1;
    #2;
    checks++; if (bus.rf_we !== 1'b0 || bus.issue_stall !== 1'b1) begin errors++; $display("FAIL rmid_in_reset: got we=%b stall=%b want 0/1", bus.rf_we, bus.issue_stall); end
    tick();
    reset = 0;
    bus.issue_valid = 1; bus.issue_use_rs1 = 1; bus.issue_rs1 = 5'd2;
    #2;
    checks++; if (bus.llu_ready !== 1'b1 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL rmid_hold_gone: got ready=%b we=%b want 1/0", bus.llu_ready, bus.rf_we); end
    checks++; if (bus.busy_count !== 6'd0 || bus.issue_stall !== 1'b0) begin errors++; $display("FAIL rmid_busy_gone: got count=%0d stall=%b want 0/0", bus.busy_count, bus.issue_stall); end
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] pick [$];
    for (int c = 0; c < 600; c++) begin
      idle();
      reset = ($urandom_range(0, 79) == 0);
      pick.delete();
      for (int i = 1; i < 32; i++) if (m_busy[i]) pick.push_back(5'(i));
      bus.issue_valid   = $urandom_range(0, 1);
      bus.issue_rs1     = 5'($urandom_range(0, 31));
      bus.issue_rs2     = 5'($urandom_range(0, 31));
      bus.issue_rd      = 5'($urandom_range(0, 31));
      bus.issue_use_rs1 = $urandom_range(0, 1);
      bus.issue_use_rs2 = $urandom_range(0, 1);
      bus.issue_wr_rd   = $urandom_range(0, 1);
      bus.issue_long    = $urandom_range(0, 1);
      bus.wb_valid      = ($urandom_range(0, 9) < 4);
      bus.wb_rd         = 5'($urandom_range(0, 31));
      bus.wb_data       = $urandom;
      bus.llu_valid     = ($urandom_range(0, 9) < 4);
      bus.llu_rd        = (pick.size() > 0 && $urandom_range(0, 3) != 0) ?
                          pick[$urandom_range(0, pick.size() - 1)] : 5'($urandom_range(0, 31));
      bus.llu_data      = $urandom;
      #2;
      checks++; if (bus.issue_stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", c, bus.issue_stall, exp_stall()); end
      checks++; if (bus.llu_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.llu_ready, exp_ready()); end
      checks++; if (bus.rf_we !== exp_we()) begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", c, bus.rf_we, exp_we()); end
      if (exp_we()) begin
        checks++; if (bus.rf_rd !== exp_rd() || bus.rf_din !== exp_din()) begin errors++; $display("FAIL rnd_port[%0d]: got rd=%0d din=%h want rd=%0d din=%h", c, bus.rf_rd, bus.rf_din, exp_rd(), exp_din()); end
      end
      checks++; if (int'(bus.busy_count) != exp_count()) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, bus.busy_count, exp_count()); end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_raw();
    test_collision();
    test_sustained();
    test_x0();
    test_waw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
